// File: rtl/run_sequencer_if.sv
// rtl/run_sequencer_if.sv - run_sequencer handshake, decoder and status bundle
interface run_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             DecAck;
  logic             DecLoadInst;
  logic             DecRegWrEn;
  logic             DecMemWrEn;
  logic             PcLoad;
  logic [PC_W-1:0]  PcAddr;
  logic             PcAdvance;
  logic             RegWrGate;
  logic             MemWrGate;
  logic             Busy;
  logic             Done;
  logic             Timeout;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output Start, StartAddr, DecAck, DecLoadInst, DecRegWrEn, DecMemWrEn,
    input  PcLoad, PcAddr, PcAdvance, RegWrGate, MemWrGate, Busy, Done,
           Timeout, CycleCount, InstrCount
  );

  modport slave (
    input  Start, StartAddr, DecAck, DecLoadInst, DecRegWrEn, DecMemWrEn,
    output PcLoad, PcAddr, PcAdvance, RegWrGate, MemWrGate, Busy, Done,
           Timeout, CycleCount, InstrCount
  );
endinterface

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - run controller: start handshake, write qualification,
// load wait states, cycle/instruction counters and watchdog
module run_sequencer #(
  parameter int PC_W     = 10,
  parameter int CNT_W    = 16,
  parameter int LOAD_LAT = 1
) (
  input logic            Clk,
  input logic            Reset_n,
  run_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0]       LAT      = 2'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [2:0]       state, state_nx;
  logic             start_q;
  logic [1:0]       wait_cnt;
  logic [CNT_W-1:0] cyc_cnt, ins_cnt;
  logic             tout;

  logic start_edge, running, wdog;
  logic adv, reg_gate, mem_gate, ins_inc, set_wait, set_tout, start_run;

  assign start_edge = bus.Start & ~start_q;
  assign running    = (state == S_EXEC) || (state == S_WAIT);
  // Fires in the cycle whose count reaches all-ones, so that cycle retires nothing.
  assign wdog       = running && (cyc_cnt >= CNT_LAST);

  always_comb begin
    state_nx  = state;
    adv       = 1'b0;
    reg_gate  = 1'b0;
    mem_gate  = 1'b0;
    ins_inc   = 1'b0;
    set_wait  = 1'b0;
    set_tout  = 1'b0;
    start_run = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_nx  = S_LOAD;
          start_run = 1'b1;
        end
      end
      S_LOAD: state_nx = S_EXEC;
      S_EXEC: begin
        if (wdog) begin
          set_tout = 1'b1;
          state_nx = S_DONE;
        end else if (bus.DecAck) begin
          state_nx = S_DONE;
        end else if (bus.DecLoadInst && (LOAD_LAT > 0)) begin
          set_wait = 1'b1;
          state_nx = S_WAIT;
        end else begin
          reg_gate = bus.DecRegWrEn;
          mem_gate = bus.DecMemWrEn;
          adv      = 1'b1;
          ins_inc  = 1'b1;
        end
      end
      S_WAIT: begin
        if (wdog) begin
          set_tout = 1'b1;
          state_nx = S_DONE;
        end else if (wait_cnt == 2'd1) begin
          reg_gate = 1'b1;
          adv      = 1'b1;
          ins_inc  = 1'b1;
          state_nx = S_EXEC;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      wait_cnt <= 2'd0;
      cyc_cnt  <= '0;
      ins_cnt  <= '0;
      tout     <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= bus.Start;
      // Clearing on the accepted start makes the LOAD cycle already show zeros.
      if (start_run || (state == S_LOAD)) begin
        wait_cnt <= 2'd0;
        cyc_cnt  <= '0;
        ins_cnt  <= '0;
        tout     <= 1'b0;
      end else begin
        if (running && (cyc_cnt != CNT_MAX)) cyc_cnt <= cyc_cnt + 1'b1;
        if (ins_inc) ins_cnt <= ins_cnt + 1'b1;
        if (set_tout) tout <= 1'b1;
        if (set_wait) wait_cnt <= LAT;
        else if ((state == S_WAIT) && (wait_cnt != 2'd0)) wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  assign bus.PcLoad     = (state == S_LOAD);
  assign bus.PcAddr     = bus.StartAddr;
  assign bus.PcAdvance  = adv;
  assign bus.RegWrGate  = reg_gate;
  assign bus.MemWrGate  = mem_gate;
  assign bus.Busy       = (state == S_LOAD) || running;
  assign bus.Done       = (state == S_DONE);
  assign bus.Timeout    = tout;
  assign bus.CycleCount = cyc_cnt;
  assign bus.InstrCount = ins_cnt;
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer (LOAD_LAT=2 unit
// for runs/stalls/reset, CNT_W=4 unit for the watchdog)
module tb_run_sequencer;
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [15:0] cyc;
    logic [15:0] ins;
    logic [9:0]  pc;
  } exp_t;

  // {PcLoad, PcAdvance, RegWrGate, MemWrGate, Busy, Done, Timeout}
  localparam logic [6:0] LD_C   = 7'b1000100;
  localparam logic [6:0] ALU_C  = 7'b0110100;
  localparam logic [6:0] ST_C   = 7'b0101100;
  localparam logic [6:0] BUSY_C = 7'b0000100;
  localparam logic [6:0] DONE_C = 7'b0000010;
  localparam logic [6:0] TO_C   = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t qa[$];
  exp_t qw[$];

  always #5 clk = ~clk;

  run_sequencer_if #(.PC_W(10), .CNT_W(16)) ia ();
  run_sequencer_if #(.PC_W(10), .CNT_W(4))  iw ();

  run_sequencer #(.PC_W(10), .CNT_W(16), .LOAD_LAT(2)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .bus(ia.slave)
  );
  run_sequencer #(.PC_W(10), .CNT_W(4), .LOAD_LAT(1)) dut_w (
    .Clk(clk), .Reset_n(rst_n), .bus(iw.slave)
  );

  function automatic logic [6:0] ctrl_a();
    return {ia.PcLoad, ia.PcAdvance, ia.RegWrGate, ia.MemWrGate, ia.Busy, ia.Done, ia.Timeout};
  endfunction

  function automatic logic [6:0] ctrl_w();
    return {iw.PcLoad, iw.PcAdvance, iw.RegWrGate, iw.MemWrGate, iw.Busy, iw.Done, iw.Timeout};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pa(input logic [6:0] c, input int cy, input int in);
    exp_t e;
    e.ctrl = c; e.cyc = 16'(cy); e.ins = 16'(in); e.pc = ia.StartAddr;
    qa.push_back(e);
  endtask

  task automatic pw(input logic [6:0] c, input int cy, input int in);
    exp_t e;
    e.ctrl = c; e.cyc = 16'(cy); e.ins = 16'(in); e.pc = iw.StartAddr;
    qw.push_back(e);
  endtask

  task automatic dec_a(input logic ack, input logic ld, input logic rw, input logic mw);
    ia.DecAck = ack; ia.DecLoadInst = ld; ia.DecRegWrEn = rw; ia.DecMemWrEn = mw;
  endtask

  task automatic dec_w(input logic ack, input logic ld, input logic rw, input logic mw);
    iw.DecAck = ack; iw.DecLoadInst = ld; iw.DecRegWrEn = rw; iw.DecMemWrEn = mw;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    logic [6:0] g;
    if (rst_n && (ia.Busy || ia.Done || ia.PcLoad)) begin
      g = ctrl_a();
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected ctrl=%b cyc=%0d ins=%0d", g, ia.CycleCount, ia.InstrCount);
      end else begin
        e = qa.pop_front();
        if (g !== e.ctrl || ia.CycleCount !== e.cyc || ia.InstrCount !== e.ins || ia.PcAddr !== e.pc) begin
          n_fail++;
          $display("FAIL a_cycle got ctrl=%b cyc=%0d ins=%0d pc=%0h want ctrl=%b cyc=%0d ins=%0d pc=%0h",
                   g, ia.CycleCount, ia.InstrCount, ia.PcAddr, e.ctrl, e.cyc, e.ins, e.pc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_w
    exp_t e;
    logic [6:0] g;
    if (rst_n && (iw.Busy || iw.Done || iw.PcLoad)) begin
      g = ctrl_w();
      n_tests++;
      if (qw.size() == 0) begin
        n_fail++;
        $display("FAIL w_unexpected ctrl=%b cyc=%0d ins=%0d", g, iw.CycleCount, iw.InstrCount);
      end else begin
        e = qw.pop_front();
        if (g !== e.ctrl || {12'd0, iw.CycleCount} !== e.cyc || {12'd0, iw.InstrCount} !== e.ins
            || iw.PcAddr !== e.pc) begin
          n_fail++;
          $display("FAIL w_cycle got ctrl=%b cyc=%0d ins=%0d pc=%0h want ctrl=%b cyc=%0d ins=%0d pc=%0h",
                   g, iw.CycleCount, iw.InstrCount, iw.PcAddr, e.ctrl, e.cyc, e.ins, e.pc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ia.Start = 1'b0; ia.StartAddr = 10'h010; dec_a(0, 0, 0, 0);
    iw.Start = 1'b0; iw.StartAddr = 10'h155; dec_w(0, 0, 0, 0);
    repeat (2) step();
    chk("reset_ctrl_a", 32'(ctrl_a()), 32'd0);
    chk("reset_cnt_a", {ia.CycleCount, ia.InstrCount}, 32'd0);
    chk("reset_ctrl_w", 32'(ctrl_w()), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic run: 3 ALU ops then Ack.
    ia.Start = 1'b1; step();
    ia.Start = 1'b0; pa(LD_C, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      dec_a(0, 0, 1, 0); pa(ALU_C, i, i); step();
    end
    dec_a(1, 0, 0, 0); pa(BUSY_C, 3, 3); step();
    // Start edge in DONE restarts and clears the counters.
    dec_a(0, 0, 0, 0); ia.Start = 1'b1; pa(DONE_C, 4, 3); step();

    // Load stall (LOAD_LAT=2), store, then Ack with write enables set.
    pa(LD_C, 0, 0); step();
    dec_a(0, 1, 1, 0); ia.Start = 1'b0; pa(BUSY_C, 0, 0); step();
    ia.Start = 1'b1; pa(BUSY_C, 1, 0); step();
    pa(ALU_C, 2, 0); step();
    dec_a(0, 0, 0, 1); pa(ST_C, 3, 1); step();
    dec_a(1, 0, 1, 1); pa(BUSY_C, 4, 2); step();
    dec_a(0, 0, 0, 0);
    pa(DONE_C, 5, 2); step();
    pa(DONE_C, 5, 2); step();
    ia.Start = 1'b0; pa(DONE_C, 5, 2); step();
    ia.Start = 1'b1; pa(DONE_C, 5, 2); step();

    // Third run, reset asynchronously in the middle of a load wait.
    ia.Start = 1'b0; pa(LD_C, 0, 0); step();
    dec_a(0, 1, 1, 0); pa(BUSY_C, 0, 0); step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(ctrl_a()), 32'd0);
    chk("async_rst_cyc", 32'(ia.CycleCount), 32'd0);
    chk("async_rst_ins", 32'(ia.InstrCount), 32'd0);
    dec_a(0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_after_rst", 32'(ctrl_a()), 32'd0);
    rst_n = 1'b0; ia.Start = 1'b1;
    #2 rst_n = 1'b1;
    step();
    chk("idle_before_edge", 32'(qa.size()), 32'd0);
    ia.Start = 1'b0; pa(LD_C, 0, 0); step();
    dec_a(1, 0, 0, 0); pa(BUSY_C, 0, 0); step();
    dec_a(0, 0, 0, 0); pa(DONE_C, 1, 0); step();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // Watchdog with CNT_W=4: endless ALU ops.
    iw.Start = 1'b1; step();
    iw.Start = 1'b0; pw(LD_C, 0, 0); step();
    for (int k = 0; k < 14; k++) begin
      dec_w(0, 0, 1, 0); pw(ALU_C, k, k); step();
    end
    pw(BUSY_C, 14, 14); step();
    pw(TO_C, 15, 14); step();
    pw(TO_C, 15, 14); step();
    iw.Start = 1'b1; pw(TO_C, 15, 14); step();
    iw.Start = 1'b0; pw(LD_C, 0, 0); step();
    dec_w(1, 0, 0, 0); pw(BUSY_C, 0, 0); step();
    dec_w(0, 0, 0, 0); pw(DONE_C, 1, 0); step();
    chk("w_queue_drained", 32'(qw.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level execution controller for the single-cycle core. It turns the bench `Start`/`Done` handshake into a program run and tells the fetch unit when to load the start address and when to advance. It qualifies the decoder's register and memory write enables so a write fires only in the cycle that commits. It inserts wait cycles for loads when data memory has read latency, and it keeps cycle and instruction counters plus a watchdog.

## Interface
Parameters:
- `PC_W`, 10, width of program counter / start address
- `CNT_W`, 16, width of cycle and instruction counters
- `LOAD_LAT`, 1, data-memory read latency in cycles (legal 0..3)

Ports:
- `Clk`  in  1  single clock; everything is rising-edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `Start`  in  1  bench request; a rising edge starts a run
- `StartAddr`  in  PC_W  first instruction address, passed through on `PcAddr`
- `DecAck`  in  1  decoder "program done" (all-ones instruction)
- `DecLoadInst`  in  1  decoder: current instruction is a load
- `DecRegWrEn`  in  1  decoder register-file write enable
- `DecMemWrEn`  in  1  decoder data-memory write enable
- `PcLoad`  out  1  fetch unit loads `PcAddr` at the next edge
- `PcAddr`  out  PC_W  equals `StartAddr` (combinational)
- `PcAdvance`  out  1  fetch unit updates PC (sequential or branch) at the next edge
- `RegWrGate`  out  1  qualified register-file write enable
- `MemWrGate`  out  1  qualified data-memory write enable
- `Busy`  out  1  a run is in progress
- `Done`  out  1  run finished; stays high until the next start
- `Timeout`  out  1  watchdog fired; sticky until the next start
- `CycleCount`  out  CNT_W  execution cycles in the current or last run
- `InstrCount`  out  CNT_W  instructions retired, excluding Ack

## Operation
- Edge detect: register `Start_q`, reset value 0. `StartEdge = Start & ~Start_q`. If `Start` is high when reset releases, that counts as an edge.
- FSM states: IDLE (reset state), LOAD, EXEC, MEMWAIT, DONE.
- **IDLE:** all outputs 0. On `StartEdge`, go to LOAD.
- **LOAD:** `PcLoad=1`, `Busy=1`. Clear `CycleCount`, `InstrCount`, `Timeout` and the wait counter. Next state is EXEC.
- **EXEC:** `Busy=1` and `CycleCount`++. Priority order:
  1. `DecAck`: no gates, no advance. Go to DONE.
  2. `DecLoadInst` and `LOAD_LAT>0`: no gates, no advance. Set the wait counter to `LOAD_LAT` and go to MEMWAIT.
  3. Otherwise: `RegWrGate=DecRegWrEn`, `MemWrGate=DecMemWrEn`, `PcAdvance=1`, `InstrCount`++. Stay in EXEC.
- **MEMWAIT:** `Busy=1`, `CycleCount`++, wait counter decrements.
  - Cycles before the last: no gates.
  - Last cycle (counter==1): `RegWrGate=1`, `PcAdvance=1`, `InstrCount`++. Go to EXEC.
  - Decoder inputs are held stable by the fetch unit, because PC does not advance during the wait.
- **DONE:** `Done=1`, `Busy=0`, counters hold. `StartEdge` goes to LOAD (restart). Other inputs are ignored.
- **Watchdog:** if `CycleCount` equals all-ones in EXEC or MEMWAIT:
  - `Timeout` is set and the next state is DONE.
  - No gate or advance fires in that cycle.
  - `CycleCount` saturates and does not wrap.
  - The watchdog has priority over every EXEC/MEMWAIT rule, including `DecAck`.
- `StartEdge` during LOAD, EXEC or MEMWAIT is ignored; `Start_q` still tracks.
- Gates and `PcAdvance` are Mealy outputs (state plus decoder inputs). `PcLoad`, `Busy`, `Done` and `Timeout` are decoded from registered state only.
- Reset mid-run: asynchronously returns to IDLE and clears counters, `Start_q` and the wait counter. All outputs go to 0 without waiting for a clock edge.

## Timing
- Reset value of every output: 0.
- Start latency: `StartEdge` sampled at edge N gives LOAD in cycle N+1. The first instruction is in EXEC in cycle N+2.
- Cycle cost per instruction:
  - Non-load instruction: 1 cycle.
  - Load: 1+`LOAD_LAT` cycles.
  - Ack: 1 cycle, then DONE.
- `LOAD_LAT=0`: a load behaves like a non-load, with `RegWrGate=DecRegWrEn` in the EXEC cycle.
- Run totals: `CycleCount` = non-load count + loads×(1+`LOAD_LAT`) + 1 (the Ack cycle). `InstrCount` = instructions before the Ack.

## Test plan
- **Basic run:** reset, pulse `Start`, StartAddr=0x010, then 3 ALU ops (RegWrEn=1) and Ack.
  - LOAD cycle has `PcLoad=1` and `PcAddr=0x010`.
  - 3 cycles with `RegWrGate=1` and `PcAdvance=1`.
  - Then `Done=1`, `CycleCount=4`, `InstrCount=3`.
- **Load stall, `LOAD_LAT=2`:** sequence load, store, Ack.
  - Load: 2 cycles with all gates 0, then 1 cycle with `RegWrGate=1` and `PcAdvance=1`.
  - Store: `MemWrGate=1`, `RegWrGate=0`.
  - Result: `CycleCount=5`, `InstrCount=2`.
- **Start handling:** hold `Start` high through DONE and raise it again mid-run.
  - Neither restarts the run.
  - Drop then raise `Start` in DONE: LOAD follows and the counters clear to 0.
- **Watchdog:** `CNT_W=4`, endless ALU ops with no Ack.
  - `Timeout=1` and `Done=1` after `CycleCount` reaches 15.
  - No gate fires in the 15th cycle.
  - `InstrCount=14`.
- **Async reset mid-MEMWAIT:** assert `Reset_n=0` between clock edges.
  - All outputs go to 0 immediately.
  - After release with `Start` low, the block stays in IDLE.
  - After release with `Start` high, LOAD follows one cycle later.
- **Ack priority:** an instruction with `DecAck=1` and `DecRegWrEn=1`/`DecMemWrEn=1` produces no gates and no advance, and DONE follows.
